switch_debounce_multi: RTL and testbench
========================================

# switch_debounce_multi

Parametrised, multi-channel successor to the single-switch debouncer. Each of N_CH asynchronous mechanical inputs (switches, buttons) is synchronised into the `clk` domain and debounced independently. A new level is accepted only after it has been stable for STABLE_CYCLES consecutive clocks. Per-channel single-cycle rise/fall strobes are produced, so downstream logic can use them directly without its own edge detectors. The block sits between board I/O pins and user control logic.

## Interface

Parameters:
- N_CH, 4: number of independent channels (≥1).
- STABLE_CYCLES, 250000: consecutive stable clocks required to accept a change (≥2). The default is 2 ms at 125 MHz.
- RST_LEVEL, 1'b0: level loaded into the synchroniser and into o_switch on reset.
- CNT_W, $clog2(STABLE_CYCLES): counter width, derived; not overridden.

Ports:
- clk  in  1  system clock (125 MHz on the target board).
- rst  in  1  reset; synchronous, active-high.
- i_switch  in  N_CH  raw asynchronous switch inputs.
- o_switch  out  N_CH  debounced levels.
- o_rise  out  N_CH  one-cycle strobe when o_switch[n] goes 0→1.
- o_fall  out  N_CH  one-cycle strobe when o_switch[n] goes 1→0.
- o_changed  out  1  OR of all o_rise and o_fall bits, registered in the same cycle as the strobes.

## Operation

Per channel n, all registers are on the rising edge of clk:
- **Synchroniser.** Two flops, s1[n] and s2[n]. s1 samples i_switch[n]; s2 samples s1. Only s2 is used downstream.
- **Counter.** cnt[n] is CNT_W bits.
  - If s2[n] == o_switch[n]: cnt[n] ← 0.
  - Else if cnt[n] == STABLE_CYCLES−1: o_switch[n] ← s2[n], cnt[n] ← 0, and the matching strobe (o_rise if s2=1, o_fall if s2=0) is asserted for this cycle.
  - Else: cnt[n] ← cnt[n]+1.
- **Bounce handling.** Any single cycle in which s2 returns to the current o_switch level clears cnt. Accumulated progress is discarded; there is no integrating or up/down behaviour.
- **Saturation.** cnt never exceeds STABLE_CYCLES−1 and never wraps.
- **Strobes.** o_rise and o_fall are registered and default to 0 every cycle. For a given channel they are never high together.
- **Channel independence.** Channels share no state. Several channels may strobe in the same cycle; o_changed is then high for that single cycle.
- **Reset (rst=1 on an edge).**
  - s1, s2 and o_switch ← {N_CH{RST_LEVEL}}.
  - cnt ← 0.
  - o_rise, o_fall, o_changed ← 0.
- **Reset mid-count.** Partial progress is lost and no strobe is issued. After release, a channel whose pin differs from RST_LEVEL needs the full latency below before it strobes.

## Timing

- **Latency.** Number the first rising edge that samples a new i_switch value as edge 1. Provided the input stays stable, o_switch and the strobe update at edge STABLE_CYCLES+2 and the strobe is visible for exactly one cycle.
  - 2 cycles are synchroniser delay.
  - STABLE_CYCLES cycles are the stability window.
- **Rejection.** A pulse or glitch shorter than STABLE_CYCLES clocks, as seen at s2, never changes o_switch.
- **Back-to-back changes.** The minimum spacing between consecutive strobes on one channel is STABLE_CYCLES clocks.
- **Throughput.** o_changed has the same timing as the strobes.
- **Output timing.** All outputs come straight from registers; there is no combinational path from input to output.

## Test plan

Use STABLE_CYCLES=16, N_CH=4 and RST_LEVEL=0 unless noted.

1. **Reset values.** Hold rst for 3 cycles with i_switch=4'b1111 → during reset o_switch=0, o_rise=o_fall=0 and o_changed=0. After release, o_switch=4'b1111 and o_rise=4'b1111 for one cycle, at edge 18 counted from the first post-reset sampling edge.
2. **Clean press.** Step ch0 from 0→1 and hold → o_switch[0]=1 and o_rise[0]=1 at edge 18, o_rise[0]=0 at edge 19. No other bits toggle.
3. **Bounce rejection.** On ch1, drive highs of 15, 5 and 10 cycles separated by 3-cycle lows, then hold high.
   - No strobe during the bounce.
   - o_rise[1] fires exactly 18 edges after the final stable high is first sampled.
4. **Release with bounce.** From stable high on ch2, drive lows of 8 and 12 cycles with 2-cycle highs, then hold low → exactly one o_fall[2] pulse, 18 edges after the final low is first sampled.
5. **Simultaneous channels.** Step ch0 and ch3 to 1 on the same cycle → o_rise=4'b1001 on a single cycle and o_changed=1 for that one cycle only.
6. **Reset mid-count plus default config.**
   - Assert rst 10 cycles into a stable-high window → no strobe; the count restarts after release.
   - Repeat scenario 2 with default parameters at 125 MHz → update occurs 250002 edges after the first sampling edge (about 2.000 ms).

Source files
------------

// File: rtl/switch_debounce_multi.sv
`timescale 1ns/1ps
// Multi-channel switch debouncer: two-flop synchroniser, per-channel stability
// counter, registered rise/fall strobes and a combined change flag.
module switch_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 250000,
  parameter bit RST_LEVEL     = 1'b0,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_switch,
  output logic [N_CH-1:0] o_switch,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic            o_changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N_CH-1:0]  s1_q, s2_q;
  logic [N_CH-1:0]  sw_q, sw_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Any cycle back at the accepted level discards all accumulated progress.
  always_comb begin
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    for (int n = 0; n < N_CH; n++) begin
      cnt_d[n] = cnt_q[n];
      if (s2_q[n] == sw_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_MAX) begin
        cnt_d[n]  = '0;
        sw_d[n]   = s2_q[n];
        rise_d[n] = s2_q[n];
        fall_d[n] = ~s2_q[n];
      end else begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end
    end
    chg_d = |{rise_d, fall_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= {N_CH{RST_LEVEL}};
      s2_q   <= {N_CH{RST_LEVEL}};
      sw_q   <= {N_CH{RST_LEVEL}};
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
      for (int n = 0; n < N_CH; n++) cnt_q[n] <= '0;
    end else begin
      s1_q   <= i_switch;
      s2_q   <= s1_q;
      sw_q   <= sw_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
      for (int n = 0; n < N_CH; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign o_switch  = sw_q;
  assign o_rise    = rise_q;
  assign o_fall    = fall_q;
  assign o_changed = chg_q;

endmodule

// File: tb/tb_switch_debounce_multi.sv
`timescale 1ns/1ps
// Bench for switch_debounce_multi: directed latency/bounce scenarios plus a
// randomized run against a window-based reference model (two configurations).
module tb_switch_debounce_multi;

  localparam int S   = 16;
  localparam int A_S = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_switch, o_switch, o_rise, o_fall;
  logic       o_changed;
  logic       a_in;
  logic [0:0] a_sw, a_rise, a_fall;
  logic       a_chg;

  int n_vec = 0;
  int n_err = 0;

  always #4 clk = ~clk;

  switch_debounce_multi #(.N_CH(4), .STABLE_CYCLES(S), .RST_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .i_switch(i_switch), .o_switch(o_switch),
    .o_rise(o_rise), .o_fall(o_fall), .o_changed(o_changed)
  );

  switch_debounce_multi #(.N_CH(1), .STABLE_CYCLES(A_S), .RST_LEVEL(1'b1)) dut_alt (
    .clk(clk), .rst(rst), .i_switch(a_in), .o_switch(a_sw),
    .o_rise(a_rise), .o_fall(a_fall), .o_changed(a_chg)
  );

  // Reference: a level is accepted once the last S synchronised samples all
  // differ from the currently accepted level.
  logic [3:0] m_s1, m_s2, m_sw, m_rise, m_fall;
  logic       m_chg;
  logic [3:0] hist[$];

  always @(posedge clk) begin
    logic flip;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_sw = '0; m_rise = '0; m_fall = '0;
      hist.delete();
    end else begin
      m_rise = '0; m_fall = '0;
      if (hist.size() >= S) begin
        for (int c = 0; c < 4; c++) begin
          flip = 1'b1;
          foreach (hist[k]) if (hist[k][c] == m_sw[c]) flip = 1'b0;
          if (flip) begin
            m_sw[c] = ~m_sw[c];
            if (m_sw[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = i_switch;
    end
    m_chg = |{m_rise, m_fall};
    hist.push_back(m_s2);
    if (hist.size() > S) void'(hist.pop_front());
  end

  logic a_s1, a_s2, a_msw, a_mrise, a_mfall;
  logic a_hist[$];

  always @(posedge clk) begin
    logic flip;
    if (rst) begin
      a_s1 = 1'b1; a_s2 = 1'b1; a_msw = 1'b1; a_mrise = 1'b0; a_mfall = 1'b0;
      a_hist.delete();
    end else begin
      a_mrise = 1'b0; a_mfall = 1'b0;
      if (a_hist.size() >= A_S) begin
        flip = 1'b1;
        foreach (a_hist[k]) if (a_hist[k] == a_msw) flip = 1'b0;
        if (flip) begin
          a_msw = ~a_msw;
          if (a_msw) a_mrise = 1'b1; else a_mfall = 1'b1;
        end
      end
      a_s2 = a_s1;
      a_s1 = a_in;
    end
    a_hist.push_back(a_s2);
    if (a_hist.size() > A_S) void'(a_hist.pop_front());
  end

  task automatic hold(input logic [3:0] v, input int n);
    @(negedge clk);
    i_switch = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_switch = 4'b1111; a_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_switch !== 4'b0000 || o_rise !== 4'b0000 || o_fall !== 4'b0000 || o_changed !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: sw=%b rise=%b fall=%b chg=%b, want 0000 0000 0000 0",
                 i, o_switch, o_rise, o_fall, o_changed);
      end
    end
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      logic [3:0] esw, er;
      @(posedge clk); #1;
      esw = (e >= 18) ? 4'b1111 : 4'b0000;
      er  = (e == 18) ? 4'b1111 : 4'b0000;
      n_vec++;
      if (o_switch !== esw || o_rise !== er || o_fall !== 4'b0000 || o_changed !== (e == 18)) begin
        n_err++;
        $display("FAIL reset_release edge%0d: sw=%b rise=%b fall=%b chg=%b, want sw=%b rise=%b fall=0000",
                 e, o_switch, o_rise, o_fall, o_changed, esw, er);
      end
    end
  endtask

  task automatic test_clean_press();
    hold(4'b0000, 22);
    i_switch = 4'b0001;
    for (int e = 1; e <= 19; e++) begin
      logic [3:0] esw, er;
      @(posedge clk); #1;
      esw = (e >= 18) ? 4'b0001 : 4'b0000;
      er  = (e == 18) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (o_switch !== esw || o_rise !== er || o_fall !== 4'b0000) begin
        n_err++;
        $display("FAIL clean_press edge%0d: sw=%b rise=%b fall=%b, want sw=%b rise=%b fall=0000",
                 e, o_switch, o_rise, o_fall, esw, er);
      end
    end
  endtask

  task automatic test_bounce();
    int   seg[6] = '{15, 3, 5, 3, 10, 3};
    logic lvl = 1'b1;
    foreach (seg[s]) begin
      repeat (seg[s]) begin
        @(negedge clk); i_switch[1] = lvl;
        @(posedge clk); #1;
        n_vec++;
        if (o_changed !== 1'b0 || o_switch !== 4'b0001) begin
          n_err++;
          $display("FAIL bounce_quiet seg%0d: sw=%b chg=%b, want sw=0001 chg=0", s, o_switch, o_changed);
        end
      end
      lvl = ~lvl;
    end
    @(negedge clk); i_switch[1] = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      logic [3:0] esw, er;
      @(posedge clk); #1;
      esw = (e >= 18) ? 4'b0011 : 4'b0001;
      er  = (e == 18) ? 4'b0010 : 4'b0000;
      n_vec++;
      if (o_switch !== esw || o_rise !== er || o_fall !== 4'b0000) begin
        n_err++;
        $display("FAIL bounce_accept edge%0d: sw=%b rise=%b fall=%b, want sw=%b rise=%b fall=0000",
                 e, o_switch, o_rise, o_fall, esw, er);
      end
    end
  endtask

  task automatic test_release_bounce();
    int   seg[4] = '{8, 2, 12, 2};
    logic lvl = 1'b0;
    hold(4'b0111, 22);
    foreach (seg[s]) begin
      repeat (seg[s]) begin
        @(negedge clk); i_switch[2] = lvl;
        @(posedge clk); #1;
        n_vec++;
        if (o_changed !== 1'b0 || o_switch !== 4'b0111) begin
          n_err++;
          $display("FAIL release_quiet seg%0d: sw=%b chg=%b, want sw=0111 chg=0", s, o_switch, o_changed);
        end
      end
      lvl = ~lvl;
    end
    @(negedge clk); i_switch[2] = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      logic [3:0] esw, ef;
      @(posedge clk); #1;
      esw = (e >= 18) ? 4'b0011 : 4'b0111;
      ef  = (e == 18) ? 4'b0100 : 4'b0000;
      n_vec++;
      if (o_switch !== esw || o_fall !== ef || o_rise !== 4'b0000) begin
        n_err++;
        $display("FAIL release_accept edge%0d: sw=%b rise=%b fall=%b, want sw=%b fall=%b rise=0000",
                 e, o_switch, o_rise, o_fall, esw, ef);
      end
    end
  endtask

  task automatic test_simultaneous();
    hold(4'b0010, 22);
    i_switch = 4'b1011;
    for (int e = 1; e <= 19; e++) begin
      logic [3:0] er;
      @(posedge clk); #1;
      er = (e == 18) ? 4'b1001 : 4'b0000;
      n_vec++;
      if (o_rise !== er || o_fall !== 4'b0000 || o_changed !== (e == 18)) begin
        n_err++;
        $display("FAIL simultaneous edge%0d: rise=%b fall=%b chg=%b, want rise=%b fall=0000 chg=%0d",
                 e, o_rise, o_fall, o_changed, er, (e == 18));
      end
    end
    n_vec++;
    if (o_switch !== 4'b1011) begin
      n_err++;
      $display("FAIL simultaneous_level: sw=%b, want 1011", o_switch);
    end
  endtask

  task automatic test_reset_mid();
    hold(4'b0000, 22);
    i_switch = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      if (e == 11) begin @(negedge clk); rst = 1'b1; end
      @(posedge clk); #1;
      n_vec++;
      if (o_switch !== 4'b0000 || o_changed !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_pre edge%0d: sw=%b chg=%b, want sw=0000 chg=0", e, o_switch, o_changed);
      end
    end
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      logic [3:0] esw, er;
      @(posedge clk); #1;
      esw = (e >= 18) ? 4'b0001 : 4'b0000;
      er  = (e == 18) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (o_switch !== esw || o_rise !== er || o_fall !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_mid_post edge%0d: sw=%b rise=%b fall=%b, want sw=%b rise=%b fall=0000",
                 e, o_switch, o_rise, o_fall, esw, er);
      end
    end
  endtask

  task automatic test_random();
    int run[4] = '{0, 0, 0, 0};
    int a_run  = 0;
    int rst_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (run[c] == 0) begin
          i_switch[c] = 1'($urandom_range(0, 1));
          run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 18) : $urandom_range(1, 30);
        end
        run[c]--;
      end
      if (a_run == 0) begin
        a_in  = 1'($urandom_range(0, 1));
        a_run = $urandom_range(1, 8);
      end
      a_run--;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      rst = (rst_left > 0);
      @(posedge clk); #1;
      n_vec++;
      if (o_switch !== m_sw || o_rise !== m_rise || o_fall !== m_fall || o_changed !== m_chg) begin
        n_err++;
        $display("FAIL random cyc%0d: sw=%b rise=%b fall=%b chg=%b, want sw=%b rise=%b fall=%b chg=%b",
                 cyc, o_switch, o_rise, o_fall, o_changed, m_sw, m_rise, m_fall, m_chg);
      end
      n_vec++;
      if (a_sw[0] !== a_msw || a_rise[0] !== a_mrise || a_fall[0] !== a_mfall || a_chg !== (a_mrise | a_mfall)) begin
        n_err++;
        $display("FAIL random_alt cyc%0d: sw=%b rise=%b fall=%b chg=%b, want sw=%b rise=%b fall=%b",
                 cyc, a_sw, a_rise, a_fall, a_chg, a_msw, a_mrise, a_mfall);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
